// File: rtl/timer_pkg.sv
// Shared constants and helpers for the timer count engine.
package timer_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] MODE_FREE     = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;

    function automatic int calc_nw(input int cnt_w);
        return cnt_w / WORD_W;
    endfunction

endpackage

// File: rtl/timer_wreg.sv
// One 32-bit slice of a byte-strobed register.
// Priority: byte write, then hold, then clear, then load.
module timer_wreg
    import timer_pkg::*;
#(
    parameter logic [WORD_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        byte_we_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              hold_i,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [WORD_W-1:0] ld_val_i,
    output logic [WORD_W-1:0] q_o
);

    logic [WORD_W-1:0] q_q;
    logic [WORD_W-1:0] q_d;
    logic [WORD_W-1:0] base;

    always_comb begin
        base = q_q;
        if (!hold_i) begin
            if (clr_i) begin
                base = '0;
            end else if (ld_i) begin
                base = ld_val_i;
            end
        end
        q_d = base;
        for (int b = 0; b < 4; b++) begin
            if (byte_we_i[b]) begin
                q_d[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/timer_counter_cmp.sv
// Timer count engine: byte-writable counter and compare register with
// free-run / periodic / one-shot match, debug halt and sticky status.
module timer_counter_cmp
    import timer_pkg::*;
#(
    parameter int               CNT_W   = 64,
    parameter logic [CNT_W-1:0] CMP_RST = '1,
    localparam int              NW      = calc_nw(CNT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NW-1:0]    cnt_wr_sel,
    input  logic [NW-1:0]    cmp_wr_sel,
    input  logic [3:0]       pstrb,
    input  logic [31:0]      wdata,
    input  logic             count_en,
    input  logic             timer_en,
    input  logic             timer_en_neg,
    input  logic [1:0]       mode,
    input  logic             dbg_halt,
    input  logic             int_en,
    input  logic             int_clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] cmp,
    output logic             match,
    output logic             int_st,
    output logic             ovf_st,
    output logic             done,
    output logic             int_out
);

    if ((CNT_W % WORD_W) != 0 || CNT_W < 32 || CNT_W > 128) begin : g_bad_cnt_w
        $error("timer_counter_cmp: CNT_W must be a multiple of 32 in 32..128");
    end

    logic             tick;
    logic             hit;
    logic             any_cnt_wr;
    logic             cnt_clr;
    logic             cnt_ld;
    logic [CNT_W-1:0] count_inc;

    logic match_q, match_d;
    logic int_st_q, int_st_d;
    logic ovf_st_q, ovf_st_d;
    logic done_q, done_d;

    assign tick       = count_en & timer_en & ~dbg_halt & ~done_q;
    assign hit        = tick & (count == cmp);
    assign any_cnt_wr = |cnt_wr_sel;
    assign count_inc  = count + CNT_W'(1);
    assign cnt_clr    = timer_en_neg | (hit & (mode == MODE_PERIODIC));
    // One-shot expiry freezes the count on the matching value.
    assign cnt_ld     = tick & ~(hit & (mode == MODE_ONESHOT));

    for (genvar i = 0; i < NW; i++) begin : g_word
        timer_wreg #(
            .RST_VAL ('0)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .byte_we_i (pstrb & {4{cnt_wr_sel[i]}}),
            .wdata_i   (wdata),
            .hold_i    (any_cnt_wr),
            .clr_i     (cnt_clr),
            .ld_i      (cnt_ld),
            .ld_val_i  (count_inc[i*WORD_W +: WORD_W]),
            .q_o       (count[i*WORD_W +: WORD_W])
        );

        timer_wreg #(
            .RST_VAL (CMP_RST[i*WORD_W +: WORD_W])
        ) u_cmp (
            .clk       (clk),
            .reset     (reset),
            .byte_we_i (pstrb & {4{cmp_wr_sel[i]}}),
            .wdata_i   (wdata),
            .hold_i    (1'b0),
            .clr_i     (1'b0),
            .ld_i      (1'b0),
            .ld_val_i  ('0),
            .q_o       (cmp[i*WORD_W +: WORD_W])
        );
    end

    always_comb begin
        match_d  = hit;
        int_st_d = hit ? 1'b1 : (int_clr ? 1'b0 : int_st_q);
        ovf_st_d = (tick & (&count)) ? 1'b1 : (int_clr ? 1'b0 : ovf_st_q);
        done_d   = done_q;
        if (any_cnt_wr || timer_en_neg) begin
            done_d = 1'b0;
        end else if (hit && mode == MODE_ONESHOT) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_q  <= 1'b0;
            int_st_q <= 1'b0;
            ovf_st_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            match_q  <= match_d;
            int_st_q <= int_st_d;
            ovf_st_q <= ovf_st_d;
            done_q   <= done_d;
        end
    end

    assign match   = match_q;
    assign int_st  = int_st_q;
    assign ovf_st  = ovf_st_q;
    assign done    = done_q;
    assign int_out = int_st_q & int_en;

endmodule

// File: tb/tb_timer_counter_cmp.sv
// Scoreboard bench: three widths (64/96/32) share one stimulus stream,
// each checked against a behavioural model of the count engine.
module tb_timer_counter_cmp;

    localparam int W [3] = '{64, 96, 32};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  cnt_sel = '0;
    logic [3:0]  cmp_sel = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] wdata = '0;
    logic        count_en = 1'b0;
    logic        timer_en = 1'b0;
    logic        timer_en_neg = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        halt = 1'b0;
    logic        int_en = 1'b0;
    logic        int_clr = 1'b0;

    always #5 clk = ~clk;

    logic [63:0] c0_cnt, c0_cmp;
    logic [95:0] c1_cnt, c1_cmp;
    logic [31:0] c2_cnt, c2_cmp;
    logic [2:0]  d_match, d_int, d_ovf, d_done, d_iout;
    logic [127:0] d_cnt [3];
    logic [127:0] d_cmp [3];

    timer_counter_cmp #(.CNT_W(64)) u_dut64 (
        .clk(clk), .reset(reset), .cnt_wr_sel(cnt_sel[1:0]), .cmp_wr_sel(cmp_sel[1:0]),
        .pstrb(pstrb), .wdata(wdata), .count_en(count_en), .timer_en(timer_en),
        .timer_en_neg(timer_en_neg), .mode(mode), .dbg_halt(halt), .int_en(int_en),
        .int_clr(int_clr), .count(c0_cnt), .cmp(c0_cmp), .match(d_match[0]),
        .int_st(d_int[0]), .ovf_st(d_ovf[0]), .done(d_done[0]), .int_out(d_iout[0]));

    timer_counter_cmp #(.CNT_W(96)) u_dut96 (
        .clk(clk), .reset(reset), .cnt_wr_sel(cnt_sel[2:0]), .cmp_wr_sel(cmp_sel[2:0]),
        .pstrb(pstrb), .wdata(wdata), .count_en(count_en), .timer_en(timer_en),
        .timer_en_neg(timer_en_neg), .mode(mode), .dbg_halt(halt), .int_en(int_en),
        .int_clr(int_clr), .count(c1_cnt), .cmp(c1_cmp), .match(d_match[1]),
        .int_st(d_int[1]), .ovf_st(d_ovf[1]), .done(d_done[1]), .int_out(d_iout[1]));

    timer_counter_cmp #(.CNT_W(32)) u_dut32 (
        .clk(clk), .reset(reset), .cnt_wr_sel(cnt_sel[0:0]), .cmp_wr_sel(cmp_sel[0:0]),
        .pstrb(pstrb), .wdata(wdata), .count_en(count_en), .timer_en(timer_en),
        .timer_en_neg(timer_en_neg), .mode(mode), .dbg_halt(halt), .int_en(int_en),
        .int_clr(int_clr), .count(c2_cnt), .cmp(c2_cmp), .match(d_match[2]),
        .int_st(d_int[2]), .ovf_st(d_ovf[2]), .done(d_done[2]), .int_out(d_iout[2]));

    assign d_cnt[0] = {64'b0, c0_cnt};
    assign d_cnt[1] = {32'b0, c1_cnt};
    assign d_cnt[2] = {96'b0, c2_cnt};
    assign d_cmp[0] = {64'b0, c0_cmp};
    assign d_cmp[1] = {32'b0, c1_cmp};
    assign d_cmp[2] = {96'b0, c2_cmp};

    typedef struct {
        int           k;
        logic [127:0] cnt;
        logic [127:0] cmp;
        bit           match;
        bit           ints;
        bit           ovf;
        bit           done;
    } exp_t;

    exp_t sb [$];

    logic [127:0] m_cnt [3];
    logic [127:0] m_cmp [3];
    bit           m_done [3];
    bit           m_int [3];
    bit           m_ovf [3];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [127:0] wmask(input int w);
        logic [127:0] one = 128'd1;
        return (w == 128) ? '1 : ((one << w) - 128'd1);
    endfunction

    // Reference: next state after the coming edge, from the rule list.
    task automatic model_push();
        for (int k = 0; k < 3; k++) begin
            exp_t         e;
            logic [127:0] m;
            logic [127:0] nc;
            logic [127:0] ncmp;
            bit           tick, hit, wr;
            int           nw;
            m  = wmask(W[k]);
            nw = W[k] / 32;
            e.k = k;
            if (reset) begin
                m_cnt[k] = '0;
                m_cmp[k] = m;
                m_done[k] = 0;
                m_int[k] = 0;
                m_ovf[k] = 0;
                e.match = 0;
            end else begin
                tick = count_en && timer_en && !halt && !m_done[k];
                hit  = tick && (m_cnt[k] == m_cmp[k]);
                wr   = 0;
                for (int i = 0; i < nw; i++) if (cnt_sel[i]) wr = 1;
                nc   = m_cnt[k];
                ncmp = m_cmp[k];
                if (wr) begin
                    for (int i = 0; i < nw; i++)
                        for (int b = 0; b < 4; b++)
                            if (cnt_sel[i] && pstrb[b]) nc[i*32+b*8 +: 8] = wdata[b*8 +: 8];
                end else if (timer_en_neg) nc = '0;
                else if (hit && mode == 2'b01) nc = '0;
                else if (hit && mode == 2'b10) nc = m_cnt[k];
                else if (tick) nc = (m_cnt[k] + 128'd1) & m;
                for (int i = 0; i < nw; i++)
                    for (int b = 0; b < 4; b++)
                        if (cmp_sel[i] && pstrb[b]) ncmp[i*32+b*8 +: 8] = wdata[b*8 +: 8];
                if (wr || timer_en_neg) m_done[k] = 0;
                else if (hit && mode == 2'b10) m_done[k] = 1;
                m_int[k] = hit ? 1'b1 : (int_clr ? 1'b0 : m_int[k]);
                m_ovf[k] = (tick && m_cnt[k] == m) ? 1'b1 : (int_clr ? 1'b0 : m_ovf[k]);
                m_cnt[k] = nc;
                m_cmp[k] = ncmp;
                e.match = hit;
            end
            e.cnt  = m_cnt[k];
            e.cmp  = m_cmp[k];
            e.ints = m_int[k];
            e.ovf  = m_ovf[k];
            e.done = m_done[k];
            sb.push_back(e);
        end
    endtask

    task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s w%0d @%0t: got %h expected %h", name, W[k], $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                exp_t e;
                int   k;
                e = sb.pop_front();
                k = e.k;
                chk("count",   k, d_cnt[k], e.cnt);
                chk("cmp",     k, d_cmp[k], e.cmp);
                chk("match",   k, 128'(d_match[k]), 128'(e.match));
                chk("int_st",  k, 128'(d_int[k]),   128'(e.ints));
                chk("ovf_st",  k, 128'(d_ovf[k]),   128'(e.ovf));
                chk("done",    k, 128'(d_done[k]),  128'(e.done));
                chk("int_out", k, 128'(d_iout[k]),  128'(e.ints & int_en));
            end
        end
    end

    task automatic step();
        model_push();
        @(negedge clk);
        reset = 0;
        cnt_sel = '0;
        cmp_sel = '0;
        timer_en_neg = 0;
        int_clr = 0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wr_cnt(input logic [3:0] s, input logic [3:0] st, input logic [31:0] d);
        cnt_sel = s; pstrb = st; wdata = d;
        step();
    endtask

    task automatic wr_cmp(input logic [3:0] s, input logic [3:0] st, input logic [31:0] d);
        cmp_sel = s; pstrb = st; wdata = d;
        step();
    endtask

    task automatic disable_timer();
        timer_en = 0; timer_en_neg = 1;
        step();
    endtask

    initial begin
        @(negedge clk);
        reset = 1; step();
        reset = 1; step();
        timer_en = 1; count_en = 1;
        run(5);
        reset = 1; step();
        reset = 1; step();

        wr_cnt(4'b0010, 4'b0101, 32'hAABBCCDD);
        run(2);

        mode = 2'b01;
        wr_cnt(4'hF, 4'hF, 32'h0);
        wr_cmp(4'hF, 4'hF, 32'h0);
        wr_cmp(4'h1, 4'hF, 32'd5);
        run(8);
        int_en = 1;
        for (int i = 0; i < 14; i++) begin
            int_clr = (i % 3 == 0);
            step();
        end

        mode = 2'b10;
        wr_cnt(4'hF, 4'hF, 32'h0);
        wr_cmp(4'h1, 4'hF, 32'd3);
        run(8);
        disable_timer();
        timer_en = 1;
        run(2);

        mode = 2'b00;
        int_clr = 1; step();
        wr_cnt(4'hE, 4'hF, 32'hFFFF_FFFF);
        wr_cnt(4'h1, 4'hF, 32'hFFFF_FFFE);
        run(4);

        halt = 1; run(10);
        halt = 0; run(2);
        timer_en = 0; run(3);
        timer_en_neg = 1; step();
        timer_en = 1;

        mode = 2'b01;
        wr_cmp(4'hF, 4'hF, 32'h0);
        run(5);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) reset = 1;
            if ($urandom_range(0, 7) == 0) cnt_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 11) == 0) cmp_sel = 4'($urandom_range(0, 15));
            pstrb = 4'($urandom_range(0, 15));
            wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
            count_en = ($urandom_range(0, 3) != 0);
            if (timer_en && $urandom_range(0, 19) == 0) begin
                timer_en = 0; timer_en_neg = 1;
            end else if (!timer_en && $urandom_range(0, 4) == 0) begin
                timer_en = 1;
            end
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            halt = ($urandom_range(0, 9) == 0);
            int_en = 1'($urandom_range(0, 1));
            int_clr = ($urandom_range(0, 7) == 0);
            step();
        end

        halt = 0;
        run(3);
        @(posedge clk);
        #3;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
